// File: rtl/gate_exerciser.sv
// gate_exerciser: sweeps a basic gate through every input combination,
// samples its output y and checks it against the truth table TRUTH.
//
// Parameters:
//   N_IN   number of gate inputs driven (1..6)
//   TRUTH  expected y per input vector; bit i = expected y when vec == i
//   SETTLE extra cycles each vector is held before y is sampled (0..15)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   start      level-sampled request to begin a sweep (ignored while busy)
//   y          output of the gate under test (combinational from vec)
//   vec        gate input vector, vec[0]=a, vec[1]=b
//   busy       sweep in progress
//   done       sweep finished; held until the next accepted start
//   pass       valid when done=1; 1 = zero mismatches
//   err_count  number of mismatching vectors in the last sweep
//   fail_vec   vector of the first mismatch; 0 if none
//
// Optional feature macro: GATE_EXERCISER_STOP_ON_FAIL_EN
//   When defined, the sweep ends at the first mismatch and vec holds the
//   failing vector.
//
// state | meaning
// IDLE  | after reset, waiting for start
// HOLD  | driving vec, waiting SETTLE cycles, then sampling y
// DONE  | sweep finished, results held, waiting for start
module gate_exerciser #(
  parameter int N_IN = 2,
  parameter logic [(2**N_IN)-1:0] TRUTH = 4'b1110,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            y,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]  SETTLE_C = SETTLE[3:0];
  localparam logic [N_IN:0] ERR_ONE = {{N_IN{1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [3:0]      wait_cnt, wait_nxt;
  logic [N_IN-1:0] vec_nxt, fail_nxt;
  logic            busy_nxt, done_nxt, pass_nxt;
  logic [N_IN:0]   err_nxt;
  logic            mismatch;

  assign mismatch = (y != TRUTH[vec]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      vec       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      vec       <= vec_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_nxt;
      fail_vec  <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    vec_nxt   = vec;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    err_nxt   = err_count;
    fail_nxt  = fail_vec;

    case (state)
      HOLD: begin
        if (wait_cnt < SETTLE_C) begin
          wait_nxt = wait_cnt + 4'd1;
        end else begin
`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
          if (mismatch) begin
            // first mismatch ends the sweep; vec stays on the failing vector
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = 1'b0;
            err_nxt   = ERR_ONE;
            fail_nxt  = vec;
          end else if (&vec) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_count == '0);
          end else begin
            vec_nxt  = vec + 1'b1;
            wait_nxt = 4'd0;
          end
`else
          if (mismatch) begin
            err_nxt = err_count + ERR_ONE;
            if (err_count == '0) fail_nxt = vec;
          end
          if (&vec) begin
            // pass includes the sample taken on this final edge
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == '0);
          end else begin
            vec_nxt  = vec + 1'b1;
            wait_nxt = 4'd0;
          end
`endif
        end
      end
      default: begin
        if (start) begin
          state_nxt = HOLD;
          vec_nxt   = '0;
          wait_nxt  = 4'd0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          err_nxt   = '0;
          fail_nxt  = '0;
        end
      end
    endcase
  end

endmodule
